// File: rtl/lvds_link_pkg.sv
// Shared framing definitions for the FPGA-to-FPGA LVDS link.
// The transmit framer and the peer deframer both use this package.
package lvds_link_pkg;

    localparam logic [7:0] SOF = 8'hA5;
    localparam logic [7:0] EOF = 8'h5A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        TRL  = 2'd3
    } state_t;

    // Header word: [31:24] SOF, [23:16] sequence, [15:8] payload length, [7:0] reserved
    typedef struct packed {
        logic [7:0] mark;
        logic [7:0] seqn;
        logic [7:0] len;
        logic [7:0] rsvd;
    } hdr_t;

    // Trailer word: [31:24] EOF, [23:16] sequence, [15:0] checksum
    typedef struct packed {
        logic [7:0]  mark;
        logic [7:0]  seqn;
        logic [15:0] csum;
    } trl_t;

    // Folds one payload word into the running 16-bit checksum
    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [31:0] w);
        return 16'(acc + w[31:16] + w[15:0]);
    endfunction

endpackage

// File: rtl/lvds_sync_fifo.sv
// Single-clock first-word-fall-through FIFO holding payload words ahead of the framer.
module lvds_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage needs no reset; discarding contents is done by clearing the pointers
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/lvds_tx_framer.sv
// Link-layer transmit framer: buffers core words and emits header/payload/trailer
// frames with sequence number and 16-bit checksum to the LVDS transmitter.
module lvds_tx_framer
    import lvds_link_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned BURST   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        tx_align_done,
    input  logic [31:0] deq_src_get,
    input  logic        RDY_deq_src_get,
    output logic        EN_deq_src_get,
    output logic [31:0] enq_tx,
    output logic        EN_enq_tx,
    input  logic        RDY_enq_tx,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      seq;
    logic [7:0]      len;
    logic [7:0]      remain;
    logic [15:0]     csum;
    logic [TW-1:0]   timer;

    logic [31:0]     fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    logic            push;
    logic            pop;
    logic            xfer;
    logic            have_burst;
    logic            launch;
    logic [7:0]      launch_len;
    hdr_t            hdr;
    trl_t            trl;

    assign push           = RDY_deq_src_get && !fifo_full;
    assign EN_deq_src_get = push;
    assign xfer           = (state != IDLE) && RDY_enq_tx;
    assign EN_enq_tx      = xfer;
    assign pop            = (state == PAY) && xfer && !fifo_empty;
    assign busy           = (state != IDLE);

    // Launch on a full burst, or on a partial one once the idle timer has expired
    assign have_burst = (fifo_count >= CW'(BURST));
    assign launch     = (state == IDLE) && tx_align_done &&
                        (have_burst || ((fifo_count != '0) && (timer == TW'(TIMEOUT))));
    assign launch_len = have_burst ? 8'(BURST) : 8'(fifo_count);

    assign hdr = '{mark: SOF, seqn: seq, len: len, rsvd: 8'h00};
    assign trl = '{mark: EOF, seqn: seq, csum: csum};

    lvds_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .din   (deq_src_get),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        enq_tx    = 32'h0;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                enq_tx = hdr;
                if (xfer) begin
                    state_nxt = PAY;
                end
            end
            PAY: begin
                enq_tx = fifo_head;
                if (xfer && (remain == 8'd1)) begin
                    state_nxt = TRL;
                end
            end
            TRL: begin
                enq_tx = trl;
                if (xfer) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame bookkeeping; nothing here moves without a transfer, so stalls hold everything
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seq         <= 8'h00;
            len         <= 8'h00;
            remain      <= 8'h00;
            csum        <= 16'h0000;
            timer       <= '0;
            frames_sent <= 16'h0000;
        end else begin
            if ((state != IDLE) || (fifo_count == '0) || launch) begin
                timer <= '0;
            end else if (timer != TW'(TIMEOUT)) begin
                timer <= timer + TW'(1);
            end

            if (launch) begin
                len    <= launch_len;
                remain <= launch_len;
                csum   <= 16'h0000;
            end

            if (pop) begin
                csum   <= csum_add(csum, fifo_head);
                remain <= remain - 8'd1;
            end

            if ((state == TRL) && xfer) begin
                seq         <= seq + 8'd1;
                frames_sent <= frames_sent + 16'd1;
            end
        end
    end

endmodule
